byte_mem_responder: RTL and testbench

- Memory-side responder for the multicycle MIPS byte bus.
- Answers the controller's memread/memwrite requests, with the address supplied by the datapath's iord mux, from an internal byte RAM.
- Optional wait states plus a ready output, for stall experiments.
- Sequential loader port fills the RAM with a program after reset. Sits beside the datapath in the chip top level.

---
 rtl/byte_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_byte_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mem_responder.sv
// rtl/byte_mem_responder.sv - byte RAM responder for the multicycle MIPS byte bus
//
// Answers memread/memwrite from the controller out of an internal 2**AWIDTH
// byte RAM, optionally stretching each access by WAIT wait states, and lets a
// sequential loader fill the RAM with a program after reset.
//
// Ports:
//   ph1, ph2    two-phase clock (ph1 slave phase, ph2 master phase)
//   reset       synchronous active-high reset, folded into the next-state logic
//   memread     read request            memwrite   write request
//   adr         byte address            writedata  store data
//   memdata     read data (holds the last value read between reads)
//   ready       access completes this cycle
//   ld_start    begin program load at address 0
//   ld_valid    ld_data is valid this cycle
//   ld_data     program byte
//   ld_busy     loader active
//   err         sticky protocol-violation flag, cleared only by reset
//
// Every state register is a master/slave pair: the master samples next-state
// on ph2 and the slave presents it on ph1, so outputs change at the start of a
// cycle and next-state is taken at the end of it. The pair is modelled with
// edge-triggered stages, which samples the same values as the latch pair under
// non-overlapping phases.

module byte_mem_responder #(
  parameter int AWIDTH = 8,
  parameter int WAIT   = 0
) (
  input  logic              ph1,
  input  logic              ph2,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [AWIDTH-1:0] adr,
  input  logic [7:0]        writedata,
  output logic [7:0]        memdata,
  output logic              ready,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_busy,
  output logic              err
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic [1:0] {IDLE, WAITING, LOAD} state_t;

  // slave (visible) state
  state_t            state;
  logic [3:0]        waitcnt;
  logic [AWIDTH-1:0] ldptr, cap_adr;
  logic [7:0]        cap_data, last_rd;
  logic              cap_wr;

  // next-state
  state_t            state_n;
  logic [3:0]        waitcnt_n;
  logic [AWIDTH-1:0] ldptr_n, cap_adr_n;
  logic [7:0]        cap_data_n, last_rd_n;
  logic              cap_wr_n, err_n;

  // master stage
  state_t            state_m;
  logic [3:0]        waitcnt_m;
  logic [AWIDTH-1:0] ldptr_m, cap_adr_m;
  logic [7:0]        cap_data_m, last_rd_m;
  logic              cap_wr_m, err_m;

  // RAM port controls for this cycle
  logic              we, rd_en, we_m;
  logic [AWIDTH-1:0] wa, ra, wa_m;
  logic [7:0]        wd, wd_m;

  logic [7:0] ram [DEPTH];

  always_comb begin
    state_n    = state;
    waitcnt_n  = waitcnt;
    ldptr_n    = ldptr;
    cap_adr_n  = cap_adr;
    cap_data_n = cap_data;
    cap_wr_n   = cap_wr;
    err_n      = err;
    we         = 1'b0;
    wa         = adr;
    wd         = writedata;
    rd_en      = 1'b0;
    ra         = adr;
    if (reset) begin
      state_n   = IDLE;
      waitcnt_n = '0;
      ldptr_n   = '0;
      cap_wr_n  = 1'b0;
      err_n     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            state_n = LOAD;
            ldptr_n = '0;
          end else if (memread || memwrite) begin
            // both at once is serviced as a write and flagged
            if (memread && memwrite) err_n = 1'b1;
            if (WAIT == 0) begin
              we    = memwrite;
              rd_en = memread && !memwrite;
            end else begin
              cap_adr_n  = adr;
              cap_data_n = writedata;
              cap_wr_n   = memwrite;
              waitcnt_n  = 4'(WAIT);
              state_n    = WAITING;
            end
          end
        end
        WAITING: begin
          wa = cap_adr;
          wd = cap_data;
          ra = cap_adr;
          if (ld_start) begin
            // in-flight access abandoned, nothing commits
            state_n   = LOAD;
            ldptr_n   = '0;
            waitcnt_n = '0;
          end else if (waitcnt <= 4'd1) begin
            we        = cap_wr;
            rd_en     = !cap_wr;
            waitcnt_n = '0;
            state_n   = IDLE;
          end else begin
            waitcnt_n = waitcnt - 4'd1;
          end
        end
        LOAD: begin
          if (memread || memwrite) err_n = 1'b1;
          wa = ldptr;
          wd = ld_data;
          if (ld_valid) begin
            we      = 1'b1;
            ldptr_n = ldptr + 1'b1;
            if (ldptr == '1) state_n = IDLE;   // wrapped after the last byte
          end else if (!ld_start) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign memdata   = rd_en ? ram[ra] : last_rd;
  assign last_rd_n = reset ? 8'h00 : memdata;
  assign ready     = (state == IDLE) ? (WAIT == 0)
                   : (state == WAITING && waitcnt <= 4'd1 && !ld_start);
  assign ld_busy   = (state == LOAD);

  always_ff @(posedge ph2) begin
    state_m    <= state_n;
    waitcnt_m  <= waitcnt_n;
    ldptr_m    <= ldptr_n;
    cap_adr_m  <= cap_adr_n;
    cap_data_m <= cap_data_n;
    cap_wr_m   <= cap_wr_n;
    err_m      <= err_n;
    last_rd_m  <= last_rd_n;
    we_m       <= we;
    wa_m       <= wa;
    wd_m       <= wd;
  end

  always_ff @(posedge ph1) begin
    state    <= state_m;
    waitcnt  <= waitcnt_m;
    ldptr    <= ldptr_m;
    cap_adr  <= cap_adr_m;
    cap_data <= cap_data_m;
    cap_wr   <= cap_wr_m;
    err      <= err_m;
    last_rd  <= last_rd_m;
  end

  // write lands at the cycle boundary, visible to the next cycle's reads
  always_ff @(posedge ph1) begin
    if (we_m) ram[wa_m] <= wd_m;
  end

endmodule

// File: tb/tb_byte_mem_responder.sv
// tb/tb_byte_mem_responder.sv - self-checking bench for byte_mem_responder

module tb_byte_mem_responder;

  localparam int NI = 4;   // 0: A8/W0, 1: A8/W3, 2: A4/W0, 3: A8/W5

  localparam bit [3:0] C_RDY = 4'b0001, C_MD = 4'b0010, C_ERR = 4'b0100, C_BSY = 4'b1000;
  localparam bit [3:0] C_ALL = 4'b1111;

  logic ph1 = 1'b0, ph2 = 1'b0;
  logic       reset [NI], memread [NI], memwrite [NI], ld_start [NI], ld_valid [NI];
  logic       ready [NI], ld_busy [NI], err [NI];
  logic [7:0] adr [NI], writedata [NI], ld_data [NI], memdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int AW = (g == 2) ? 4 : 8;
    localparam int WT = (g == 1) ? 3 : (g == 3) ? 5 : 0;
    byte_mem_responder #(.AWIDTH(AW), .WAIT(WT)) dut (
      .ph1(ph1), .ph2(ph2), .reset(reset[g]),
      .memread(memread[g]), .memwrite(memwrite[g]),
      .adr(adr[g][AW-1:0]), .writedata(writedata[g]),
      .memdata(memdata[g]), .ready(ready[g]),
      .ld_start(ld_start[g]), .ld_valid(ld_valid[g]), .ld_data(ld_data[g]),
      .ld_busy(ld_busy[g]), .err(err[g])
    );
  end

  initial forever begin
    #5 ph1 = 1'b1;
    #5 ph1 = 1'b0;
    #5 ph2 = 1'b1;
    #5 ph2 = 1'b0;
  end

  typedef struct {
    int       inst;
    bit       rst, rd, wr;
    bit [7:0] a, wd;
    bit       lds, ldv;
    bit [7:0] ldd;
    bit [3:0] chk;
    bit       rdy;
    bit [7:0] md;
    bit       er, busy;
    string    name;
  } vec_t;

  typedef struct {
    int       inst;
    bit [3:0] chk;
    bit       rdy;
    bit [7:0] md;
    bit       er, busy;
    string    name;
  } exp_t;

  vec_t vecs [$];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(int inst, bit rst, bit rd, bit wr, bit [7:0] a, bit [7:0] wd,
                              bit lds, bit ldv, bit [7:0] ldd, bit [3:0] chk, bit rdy,
                              bit [7:0] md, bit er, bit busy, string name);
    vec_t v;
    v.inst = inst; v.rst = rst; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
    v.lds = lds; v.ldv = ldv; v.ldd = ldd; v.chk = chk; v.rdy = rdy;
    v.md = md; v.er = er; v.busy = busy; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic void acc(int inst, bit rd, bit wr, bit [7:0] a, bit [7:0] wd, bit [3:0] chk,
                              bit rdy, bit [7:0] md, bit er, bit busy, string name);
    add(inst, 1'b0, rd, wr, a, wd, 1'b0, 1'b0, 8'h00, chk, rdy, md, er, busy, name);
  endfunction

  function automatic void ldc(int inst, bit lds, bit ldv, bit [7:0] ldd, bit [3:0] chk,
                              bit rdy, bit er, bit busy, string name);
    add(inst, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, lds, ldv, ldd, chk & ~C_MD, rdy, 8'h00, er, busy, name);
  endfunction

  task automatic check_out();
    exp_t e;
    int   k;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
      return;
    end
    e = sb.pop_front();
    k = e.inst;
    if (e.chk[0]) begin
      n_cmp++;
      if (ready[k] !== e.rdy) begin
        n_bad++;
        $display("FAIL %s[%0d] ready: got %0b want %0b", e.name, k, ready[k], e.rdy);
      end
    end
    if (e.chk[1]) begin
      n_cmp++;
      if (memdata[k] !== e.md) begin
        n_bad++;
        $display("FAIL %s[%0d] memdata: got %02h want %02h", e.name, k, memdata[k], e.md);
      end
    end
    if (e.chk[2]) begin
      n_cmp++;
      if (err[k] !== e.er) begin
        n_bad++;
        $display("FAIL %s[%0d] err: got %0b want %0b", e.name, k, err[k], e.er);
      end
    end
    if (e.chk[3]) begin
      n_cmp++;
      if (ld_busy[k] !== e.busy) begin
        n_bad++;
        $display("FAIL %s[%0d] ld_busy: got %0b want %0b", e.name, k, ld_busy[k], e.busy);
      end
    end
  endtask

  logic [7:0] prog [4];

  initial begin
    vec_t v;
    exp_t e;
    prog[0] = 8'h8C; prog[1] = 8'h10; prog[2] = 8'h00; prog[3] = 8'h04;

    // ---------------- instance 0: WAIT=0 ----------------
    acc(0, 0, 0, 8'h00, 8'h00, C_ALL, 1, 8'h00, 0, 0, "rst0");
    ldc(0, 1, 0, 8'h00, C_RDY | C_BSY, 1, 0, 0, "ld0_start");
    for (int i = 0; i < 4; i++) ldc(0, 0, 1, prog[i], C_RDY | C_BSY, 0, 0, 1, "ld0_byte");
    ldc(0, 0, 0, 8'h00, C_BSY, 0, 0, 1, "ld0_tail");
    for (int i = 0; i < 4; i++)
      acc(0, 1, 0, 8'(i), 8'h00, C_RDY | C_MD | C_BSY, 1, prog[i], 0, 0, "rd0_prog");
    acc(0, 0, 0, 8'h00, 8'h00, C_RDY | C_MD, 1, 8'h04, 0, 0, "md_hold0");
    acc(0, 0, 1, 8'h40, 8'h5A, C_RDY | C_ERR, 1, 8'h00, 0, 0, "wr40_a");
    acc(0, 1, 0, 8'h40, 8'h00, C_MD, 1, 8'h5A, 0, 0, "rd40_a");
    acc(0, 0, 1, 8'h40, 8'hA5, C_RDY | C_MD, 1, 8'h5A, 0, 0, "wr40_b");
    acc(0, 1, 0, 8'h40, 8'h00, C_RDY | C_MD, 1, 8'hA5, 0, 0, "rd40_b");
    acc(0, 1, 1, 8'h05, 8'h3C, C_RDY | C_ERR, 1, 8'h00, 0, 0, "rdwr05");
    acc(0, 1, 0, 8'h05, 8'h00, C_MD | C_ERR, 1, 8'h3C, 1, 0, "rd05");
    acc(0, 0, 0, 8'h00, 8'h00, C_ERR, 1, 8'h00, 1, 0, "err_sticky0");
    add(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 0, 0, "rst0_pulse");
    acc(0, 0, 0, 8'h00, 8'h00, C_ALL, 1, 8'h00, 0, 0, "rst0_again");

    // ---------------- instance 2: AWIDTH=4 loader wrap ----------------
    acc(2, 0, 0, 8'h00, 8'h00, C_ALL, 1, 8'h00, 0, 0, "rst2");
    ldc(2, 1, 0, 8'h00, C_BSY, 1, 0, 0, "ld2_start");
    for (int i = 0; i < 17; i++)
      ldc(2, 0, 1, 8'(i), C_RDY | C_BSY, (i == 16), 0, (i < 16), "ld2_byte");
    for (int i = 0; i < 16; i++)
      acc(2, 1, 0, 8'(i), 8'h00, C_RDY | C_MD, 1, 8'(i), 0, 0, "rd2_wrap");
    ldc(2, 1, 0, 8'h00, C_ERR, 1, 0, 0, "ld2_again");
    acc(2, 1, 0, 8'h03, 8'h00, C_ALL, 0, 8'h0F, 0, 1, "rd_in_load");
    acc(2, 0, 0, 8'h00, 8'h00, C_RDY | C_ERR | C_BSY, 1, 8'h00, 1, 0, "load_err");
    acc(2, 1, 0, 8'h03, 8'h00, C_MD, 1, 8'h03, 1, 0, "rd2_after_load");

    // ---------------- instance 1: WAIT=3 ----------------
    acc(1, 0, 0, 8'h00, 8'h00, C_ALL, 0, 8'h00, 0, 0, "rst1");
    ldc(1, 1, 0, 8'h00, C_RDY | C_BSY, 0, 0, 0, "ld1_start");
    for (int i = 0; i < 4; i++) ldc(1, 0, 1, prog[i], C_RDY | C_BSY, 0, 0, 1, "ld1_byte");
    ldc(1, 0, 0, 8'h00, C_BSY, 0, 0, 1, "ld1_tail");
    for (int j = 0; j < 4; j++)
      acc(1, 1, 0, 8'h00, 8'h00, (j == 3) ? (C_RDY | C_MD) : C_RDY, (j == 3), 8'h8C, 0, 0, "w3_rd0");
    for (int j = 0; j < 4; j++)
      acc(1, 1, 0, 8'h02, 8'h00, C_RDY | C_MD, (j == 3), (j == 3) ? 8'h00 : 8'h8C, 0, 0, "w3_rd2");
    acc(1, 0, 0, 8'h00, 8'h00, C_RDY | C_MD, 0, 8'h00, 0, 0, "w3_idle");
    for (int j = 0; j < 4; j++)
      acc(1, 0, 1, 8'h01, 8'h77, C_RDY | C_MD, (j == 3), 8'h00, 0, 0, "w3_wr1");
    for (int j = 0; j < 4; j++)
      acc(1, 1, 0, 8'h01, 8'h00, (j == 3) ? (C_RDY | C_MD) : C_RDY, (j == 3), 8'h77, 0, 0, "w3_rd1");
    for (int j = 0; j < 3; j++)
      acc(1, 0, 1, 8'h03, 8'h99, C_RDY, 0, 8'h00, 0, 0, "w3_wr3");
    add(1, 0, 0, 1, 8'h03, 8'h99, 1, 0, 8'h00, C_RDY | C_BSY, 0, 8'h00, 0, 0, "abandon");
    ldc(1, 0, 0, 8'h00, C_RDY | C_BSY, 0, 0, 1, "abandon_load");
    for (int j = 0; j < 4; j++)
      acc(1, 1, 0, 8'h03, 8'h00, (j == 3) ? (C_RDY | C_MD) : C_RDY, (j == 3), 8'h04, 0, 0, "w3_rd3");

    // ---------------- instance 3: WAIT=5, reset mid-WAITING ----------------
    acc(3, 0, 0, 8'h00, 8'h00, C_ALL, 0, 8'h00, 0, 0, "rst3");
    ldc(3, 1, 0, 8'h00, C_BSY, 0, 0, 0, "ld3_start");
    for (int i = 0; i < 9; i++) ldc(3, 0, 1, 8'(i * 17), C_BSY, 0, 0, 1, "ld3_byte");
    ldc(3, 0, 0, 8'h00, C_BSY, 0, 0, 1, "ld3_tail");
    for (int j = 0; j < 3; j++)
      acc(3, 0, 1, 8'h07, 8'hEE, C_RDY, 0, 8'h00, 0, 0, "w5_wr7");
    add(3, 1, 0, 1, 8'h07, 8'hEE, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 0, 0, "rst3_pulse");
    acc(3, 0, 0, 8'h00, 8'h00, C_ALL, 0, 8'h00, 0, 0, "post_rst3");
    for (int j = 0; j < 6; j++)
      acc(3, 1, 0, 8'h07, 8'h00, (j == 5) ? (C_RDY | C_MD) : C_RDY, (j == 5), 8'h77, 0, 0, "w5_rd7");
    for (int j = 0; j < 6; j++)
      acc(3, 1, 0, 8'h08, 8'h00, (j == 5) ? (C_RDY | C_MD | C_ERR) : C_RDY, (j == 5), 8'h88, 0, 0, "w5_rd8");

    // reset every instance into IDLE
    for (int k = 0; k < NI; k++) begin
      reset[k] = 1'b1; memread[k] = 1'b0; memwrite[k] = 1'b0; adr[k] = 8'h00;
      writedata[k] = 8'h00; ld_start[k] = 1'b0; ld_valid[k] = 1'b0; ld_data[k] = 8'h00;
    end
    repeat (3) @(posedge ph1);
    #2;
    for (int k = 0; k < NI; k++) reset[k] = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(posedge ph1);
      #2;
      for (int k = 0; k < NI; k++) begin
        reset[k] = 1'b0; memread[k] = 1'b0; memwrite[k] = 1'b0; adr[k] = 8'h00;
        writedata[k] = 8'h00; ld_start[k] = 1'b0; ld_valid[k] = 1'b0; ld_data[k] = 8'h00;
      end
      reset[v.inst]     = v.rst;
      memread[v.inst]   = v.rd;
      memwrite[v.inst]  = v.wr;
      adr[v.inst]       = v.a;
      writedata[v.inst] = v.wd;
      ld_start[v.inst]  = v.lds;
      ld_valid[v.inst]  = v.ldv;
      ld_data[v.inst]   = v.ldd;
      e.inst = v.inst; e.chk = v.chk; e.rdy = v.rdy; e.md = v.md;
      e.er = v.er; e.busy = v.busy; e.name = v.name;
      sb.push_back(e);
      #6;
      check_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
